// File: rtl/usb_fifo_responder.sv
// FT245-style sync FIFO stand-in facing usb_control: serves framed command packets
// on the read side and parses upstream packets (preamble, header, payload) on the write side.
module usb_fifo_responder #(
  parameter int PAYLOAD_LEN    = 492,
  parameter int BS_PACKETS     = 67,
  parameter int TXE_GAP_PERIOD = 0,
  parameter int TXE_GAP_LEN    = 4
) (
  input  logic         usb_clock,
  input  logic         reset,
  input  logic         n_RD,
  input  logic         n_OE,
  input  logic         n_WR,
  input  logic         n_SIWU,
  input  logic [7:0]   usb_data_in,
  output logic [7:0]   usb_data_out,
  output logic         usb_data_drive,
  output logic         n_RXF,
  output logic         n_TXE,
  input  logic         cmd_start,
  input  logic [191:0] cmd_header,
  output logic         cmd_busy,
  input  logic         tx_stall,
  output logic [7:0]   rx_byte,
  output logic         rx_byte_valid,
  output logic [8:0]   rx_byte_idx,
  output logic         pkt_done,
  output logic [1:0]   pkt_type,
  output logic [15:0]  pkt_fw,
  output logic         pkt_clip,
  output logic [7:0]   pkt_pn,
  output logic         pn_seq_err,
  output logic [15:0]  pkt_count,
  output logic [7:0]   err_count
);

  localparam logic [8:0]  LAST_IDX   = 9'(PAYLOAD_LEN - 1);
  localparam logic [7:0]  LAST_PN    = 8'(BS_PACKETS - 1);
  localparam logic [15:0] GAP_PERIOD = 16'(TXE_GAP_PERIOD);
  localparam logic [15:0] GAP_LEN    = 16'(TXE_GAP_LEN);

  typedef enum logic [1:0] {HUNT, HDR, DATA} state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [191:0] cmd_hdr;
  logic [4:0]   cmd_idx;
  logic [4:0]   hdr_k;
  logic         accept;
  logic [15:0]  acc_cnt, acc_cnt_next, gap_cnt, gap_cnt_next;
  state_t       state;
  logic [2:0]   pre_cnt, hdr_idx;
  logic [8:0]   data_idx;
  logic [23:0]  h_type;
  logic [15:0]  h_fw;
  logic         h_clip;
  logic [7:0]   h_pn, last_pn, pn_expect;
  logic         pn_valid;
  logic [1:0]   type_dec;

  assign usb_data_drive = !n_OE;
  assign accept         = !n_WR && !n_TXE;
  assign hdr_k          = cmd_idx - 5'd8;
  assign pn_expect      = (last_pn == LAST_PN) ? 8'd0 : last_pn + 8'd1;

  always_comb begin
    usb_data_out = 8'h00;
    if (cmd_busy) begin
      if (cmd_idx < 5'd7)       usb_data_out = 8'h55;
      else if (cmd_idx == 5'd7) usb_data_out = 8'hD5;
      else                      usb_data_out = cmd_hdr[(8'd191 - {hdr_k, 3'b000}) -: 8];
    end
  end

  always_comb begin
    type_dec = 2'd3;
    if (h_type == 24'h525830)      type_dec = 2'd1;
    else if (h_type == 24'h425330) type_dec = 2'd2;
  end

  // Gap scheduling is computed one step ahead so n_TXE rises right after the triggering byte
  always_comb begin
    acc_cnt_next = acc_cnt;
    gap_cnt_next = gap_cnt;
    if (gap_cnt != 16'd0) gap_cnt_next = gap_cnt - 16'd1;
    if (accept && GAP_PERIOD != 16'd0) begin
      if (acc_cnt == GAP_PERIOD - 16'd1) begin
        acc_cnt_next = 16'd0;
        gap_cnt_next = GAP_LEN;
      end else begin
        acc_cnt_next = acc_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge usb_clock) begin
    if (cmd_start && !cmd_busy) cmd_hdr <= cmd_header;
    if (accept && state == HDR) begin
      case (hdr_idx)
        3'd0:    h_type[23:16] <= usb_data_in;
        3'd1:    h_type[15:8]  <= usb_data_in;
        3'd2:    h_type[7:0]   <= usb_data_in;
        3'd3:    h_fw[15:8]    <= usb_data_in;
        3'd4:    h_fw[7:0]     <= usb_data_in;
        3'd5:    h_clip        <= usb_data_in[0];
        3'd6:    h_pn          <= usb_data_in;
        default: ;
      endcase
    end
  end

  always_ff @(posedge usb_clock or negedge reset) begin
    if (!reset) begin
      cmd_idx  <= 5'd0;
      cmd_busy <= 1'b0;
      n_RXF    <= 1'b1;
      n_TXE    <= 1'b1;
      acc_cnt  <= 16'd0;
      gap_cnt  <= 16'd0;
    end else begin
      n_TXE   <= tx_stall | (gap_cnt_next != 16'd0);
      acc_cnt <= acc_cnt_next;
      gap_cnt <= gap_cnt_next;
      if (cmd_start && !cmd_busy) begin
        cmd_idx  <= 5'd0;
        cmd_busy <= 1'b1;
        n_RXF    <= 1'b0;
      end else if (!n_RD && !n_OE && !n_RXF) begin
        if (cmd_idx == 5'd31) begin
          cmd_idx  <= 5'd0;
          cmd_busy <= 1'b0;
          n_RXF    <= 1'b1;
        end else begin
          cmd_idx <= cmd_idx + 5'd1;
        end
      end
    end
  end

  always_ff @(posedge usb_clock or negedge reset) begin
    if (!reset) begin
      state         <= HUNT;
      pre_cnt       <= 3'd0;
      hdr_idx       <= 3'd0;
      data_idx      <= 9'd0;
      rx_byte       <= 8'd0;
      rx_byte_valid <= 1'b0;
      rx_byte_idx   <= 9'd0;
      pkt_done      <= 1'b0;
      pkt_type      <= 2'd0;
      pkt_fw        <= 16'd0;
      pkt_clip      <= 1'b0;
      pkt_pn        <= 8'd0;
      pn_seq_err    <= 1'b0;
      pkt_count     <= 16'd0;
      err_count     <= 8'd0;
      last_pn       <= 8'd0;
      pn_valid      <= 1'b0;
    end else begin
      rx_byte_valid <= 1'b0;
      pkt_done      <= 1'b0;
      pn_seq_err    <= 1'b0;
      // A flush inside a packet means the controller sent a short packet
      if (!n_SIWU && state != HUNT) begin
        err_count <= sat_inc8(err_count);
        state     <= HUNT;
        pre_cnt   <= 3'd0;
      end else if (accept) begin
        case (state)
          HUNT: begin
            if (usb_data_in == 8'h55) begin
              pre_cnt <= (pre_cnt == 3'd7) ? 3'd7 : pre_cnt + 3'd1;
            end else if (usb_data_in == 8'hD5 && pre_cnt == 3'd7) begin
              state   <= HDR;
              hdr_idx <= 3'd0;
              pre_cnt <= 3'd0;
            end else begin
              if (pre_cnt != 3'd0) err_count <= sat_inc8(err_count);
              pre_cnt <= 3'd0;
            end
          end
          HDR: begin
            if (hdr_idx == 3'd7) begin
              state    <= DATA;
              data_idx <= 9'd0;
            end else begin
              hdr_idx <= hdr_idx + 3'd1;
            end
          end
          DATA: begin
            rx_byte       <= usb_data_in;
            rx_byte_valid <= 1'b1;
            rx_byte_idx   <= data_idx;
            if (data_idx == LAST_IDX) begin
              pkt_done  <= 1'b1;
              pkt_type  <= type_dec;
              pkt_fw    <= h_fw;
              pkt_clip  <= h_clip;
              pkt_pn    <= h_pn;
              pkt_count <= sat_inc16(pkt_count);
              state     <= HUNT;
              if (type_dec == 2'd2) begin
                if (pn_valid && h_pn != pn_expect) pn_seq_err <= 1'b1;
                last_pn  <= h_pn;
                pn_valid <= 1'b1;
              end
            end else begin
              data_idx <= data_idx + 9'd1;
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule
